ssd1306_spi_receiver: RTL and testbench
=======================================

# ssd1306_spi_receiver

Synthesizable SPI responder that models the display side of the 4-wire SSD1306 OLED link.
It oversamples CS#, D/C#, SCLK and MOSI on the system clock, reassembles command and data bytes, and tracks the SSD1306 addressing state. Each data byte becomes a framebuffer write strobe with a page/column address.
It lets the frequency-counter display driver be looped back and checked on-chip or in simulation without a physical panel.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer depth on all four link inputs (≥2).

Ports:
- clk  in  1  system clock; must be ≥4× SCLK frequency
- rst_n  in  1  asynchronous, active-low reset
- oled_rstn_in  in  1  panel reset from driver; low = soft reset of decoder state
- oled_csn_in  in  1  chip select, active low
- oled_dc_in  in  1  1 = data byte, 0 = command byte
- oled_clk_in  in  1  SCLK, SPI mode 0
- oled_mosi_in  in  1  serial data, MSB first
- byte_out  out  8  last received byte
- byte_dc  out  1  D/C# sampled with the 8th bit
- byte_valid  out  1  one-cycle strobe per completed byte
- frame_err  out  1  one-cycle strobe: CS# deasserted with 1–7 bits pending
- fb_we  out  1  one-cycle framebuffer write strobe
- fb_addr  out  10  {page[2:0], column[6:0]}
- fb_data  out  8  pixel byte, bit0 = top row of page
- display_on  out  1  state set by 0xAE/0xAF

## Operation
- All four link inputs pass through SYNC_STAGES flops. SCLK rising edge is detected on the synchronized signal.
- While CS# is low, each SCLK rise shifts MOSI into the shift register and increments the bit counter (3 bits).
- At the 8th bit, the receiver loads byte_out, latches byte_dc from synchronized D/C#, pulses byte_valid and clears the bit counter.
- CS# high clears the bit counter. If the count was non-zero, frame_err pulses once and the partial byte is discarded.
- Command decoder FSM states: IDLE, PARAM, COL_START, COL_END, PG_START, PG_END, MODE.
  - 0x21 → COL_START → COL_END: sets col_start, col_end and col = col_start.
  - 0x22 → PG_START → PG_END: sets pg_start, pg_end and page = pg_start.
  - 0x20 → MODE: bits[1:0] select 00 horizontal, 01 vertical, 10 page; 11 is ignored.
  - 0xB0–0xB7: page = low 3 bits.
  - 0x00–0x0F / 0x10–0x1F: set low / high column nibble. High nibble is masked to 3 bits.
  - 0xAE / 0xAF: display_on 0 / 1.
  - Other commands with parameters enter PARAM with a skip count taken from the package table. Parameter bytes are consumed without effect.
  - All other command bytes are no-ops.
- A data byte (byte_dc = 1) arriving while in a command state aborts that command and returns the FSM to IDLE.
- Data byte handling: fb_we pulses with fb_addr = {page, col} and fb_data = byte_out. The address then advances:
  - Horizontal: col++. When col passes col_end, col = col_start and page++. When page passes pg_end, page = pg_start.
  - Vertical: the same rule with the page/column roles swapped.
  - Page: col++ and wraps 127 → 0. Page is unchanged.
- Soft reset (oled_rstn_in low, synchronized) returns the decoder to its reset values:
  - FSM IDLE, horizontal mode, col = 0, page = 0.
  - col range 0–127, page range 0–7, display_on = 0.
  - Bit counter cleared.
  - A partial byte at soft reset does not raise frame_err.

## Timing
- Reset values: byte_out 0x00, byte_dc 0, byte_valid 0, frame_err 0, fb_we 0, fb_addr 0, fb_data 0x00, display_on 0.
- byte_valid asserts SYNC_STAGES+1 clk edges after the 8th SCLK rise is first captured. Sampling jitter is ±1 clk.
- fb_we asserts exactly 1 clk after byte_valid for the same byte.
- Consecutive bytes with no CS# gap are supported. Minimum SCLK high and low time is 2 clk each.
- When byte_valid and CS# deassertion coincide, the byte is completed and no frame_err is raised.
- rst_n assertion mid-byte clears all state immediately.

## Configuration
- SSD1306_RX_CMD_DECODE_EN defined: full command decoder and address generator are built as above.
- Macro undefined: only byte reassembly is built. fb_we, fb_addr, fb_data and display_on are tied to 0. byte_out, byte_dc, byte_valid and frame_err are unchanged.

## Structure
- Package ssd1306_rx_pkg holds:
  - command opcode constants,
  - addressing-mode enum,
  - decoder FSM state enum,
  - param-count function: 1 for 0x81, 0x8D, 0xA8, 0xD3, 0xD5, 0xD9, 0xDA, 0xDB; 2 for 0xA3; 5 for 0x29, 0x2A; 6 for 0x26, 0x27; 0 otherwise.
- One sub-module, ssd1306_rx_shifter, contains the synchronizers, edge detect and byte assembly. The top level contains the decoder and the address logic.

## Test plan
- CS# low, D/C# = 0, send 0xAF → byte_valid with byte_out 0xAF, byte_dc 0; display_on = 1.
- Send 0x21,0x10,0x11, then 0x22,0x02,0x03, then 4 data bytes → fb_addr sequence {2,0x10}, {2,0x11}, {3,0x10}, {3,0x11}.
- Horizontal mode, full range, 1025 data bytes → last write at {0,0}, the 1024-entry wrap.
- Send 0x20,0x02 (page mode), then 0xB5, 0x0F, 0x17, then 2 data bytes → addresses {5,0x7F}, {5,0x00}.
- Send 5 bits, then CS# high → single frame_err pulse, no byte_valid. The next full byte 0x81 is received intact, and its following param 0xAE is skipped, so display_on is unchanged.
- oled_rstn_in low mid-stream → col, page and mode return to reset values. The next data byte writes fb_addr 0.

Source files
------------

// File: rtl/ssd1306_rx_pkg.sv
// Shared opcodes, enums and the parameter-count table for the SSD1306 link receiver.
package ssd1306_rx_pkg;

  localparam logic [7:0] CMD_SET_MODE  = 8'h20;
  localparam logic [7:0] CMD_COL_ADDR  = 8'h21;
  localparam logic [7:0] CMD_PAGE_ADDR = 8'h22;
  localparam logic [7:0] CMD_PAGE_BASE = 8'hB0;
  localparam logic [7:0] CMD_DISP_OFF  = 8'hAE;
  localparam logic [7:0] CMD_DISP_ON   = 8'hAF;

  typedef enum logic [1:0] {
    MODE_HORIZ = 2'b00,
    MODE_VERT  = 2'b01,
    MODE_PAGE  = 2'b10
  } addr_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PARAM,
    ST_COL_START,
    ST_COL_END,
    ST_PG_START,
    ST_PG_END,
    ST_MODE
  } dec_state_e;

  // Number of trailing parameter bytes for commands the decoder does not interpret.
  function automatic logic [2:0] param_count(input logic [7:0] cmd);
    case (cmd)
      8'h81, 8'h8D, 8'hA8, 8'hD3,
      8'hD5, 8'hD9, 8'hDA, 8'hDB: param_count = 3'd1;
      8'hA3:                      param_count = 3'd2;
      8'h29, 8'h2A:               param_count = 3'd5;
      8'h26, 8'h27:               param_count = 3'd6;
      default:                    param_count = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/ssd1306_rx_shifter.sv
// Link-input synchronizers, SCLK rise detect and MSB-first byte assembly.
module ssd1306_rx_shifter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rstn_in,
  input  logic       csn_in,
  input  logic       dc_in,
  input  logic       sclk_in,
  input  logic       mosi_in,
  output logic [7:0] byte_out,
  output logic       byte_dc,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       soft_rst
);

  // Bit order {rstn, csn, dc, sclk, mosi}; idle = panel out of reset, deselected.
  localparam logic [4:0] SYNC_IDLE = 5'b11000;

  logic [4:0] sync_reg [SYNC_STAGES];
  logic [4:0] sync_out;
  logic       rstn_s, csn_s, dc_s, sclk_s, mosi_s;
  logic       sclk_prev;
  logic       rise;
  logic [6:0] shift;
  logic [2:0] bit_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_reg[i] <= SYNC_IDLE;
    end else begin
      sync_reg[0] <= {rstn_in, csn_in, dc_in, sclk_in, mosi_in};
      for (int i = 1; i < SYNC_STAGES; i++) sync_reg[i] <= sync_reg[i-1];
    end
  end

  assign sync_out = sync_reg[SYNC_STAGES-1];
  assign {rstn_s, csn_s, dc_s, sclk_s, mosi_s} = sync_out;
  assign rise     = sclk_s & ~sclk_prev;
  assign soft_rst = ~rstn_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_prev  <= 1'b0;
      shift      <= '0;
      bit_cnt    <= '0;
      byte_out   <= '0;
      byte_dc    <= 1'b0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sclk_prev  <= sclk_s;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (!rstn_s) begin
        bit_cnt <= '0;
      // A final rise that lands with CS# release still completes the byte.
      end else if (rise && (!csn_s || bit_cnt == 3'd7)) begin
        shift   <= {shift[5:0], mosi_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_out   <= {shift, mosi_s};
          byte_dc    <= dc_s;
          byte_valid <= 1'b1;
        end
      end else if (csn_s) begin
        bit_cnt   <= '0;
        frame_err <= (bit_cnt != 3'd0);
      end
    end
  end

endmodule

// File: rtl/ssd1306_spi_receiver.sv
// SSD1306 display-side SPI model: byte reassembly plus, with SSD1306_RX_CMD_DECODE_EN
// defined, the command decoder and framebuffer address generator.
module ssd1306_spi_receiver
  import ssd1306_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       oled_rstn_in,
  input  logic       oled_csn_in,
  input  logic       oled_dc_in,
  input  logic       oled_clk_in,
  input  logic       oled_mosi_in,
  output logic [7:0] byte_out,
  output logic       byte_dc,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       fb_we,
  output logic [9:0] fb_addr,
  output logic [7:0] fb_data,
  output logic       display_on
);

  logic soft_rst;

  ssd1306_rx_shifter #(.SYNC_STAGES(SYNC_STAGES)) u_shifter (
    .clk        (clk),
    .rst_n      (rst_n),
    .rstn_in    (oled_rstn_in),
    .csn_in     (oled_csn_in),
    .dc_in      (oled_dc_in),
    .sclk_in    (oled_clk_in),
    .mosi_in    (oled_mosi_in),
    .byte_out   (byte_out),
    .byte_dc    (byte_dc),
    .byte_valid (byte_valid),
    .frame_err  (frame_err),
    .soft_rst   (soft_rst)
  );

`ifdef SSD1306_RX_CMD_DECODE_EN
  dec_state_e state_reg, state_next;
  addr_mode_e mode_reg, mode_next;
  logic [6:0] col_reg, col_next, col_start_reg, col_start_next, col_end_reg, col_end_next;
  logic [2:0] page_reg, page_next, pg_start_reg, pg_start_next, pg_end_reg, pg_end_next;
  logic [2:0] skip_reg, skip_next;
  logic       disp_reg, disp_next;
  logic       fb_we_reg, fb_we_next;
  logic [9:0] fb_addr_reg, fb_addr_next;
  logic [7:0] fb_data_reg, fb_data_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      mode_reg      <= MODE_HORIZ;
      col_reg       <= '0;
      col_start_reg <= '0;
      col_end_reg   <= 7'd127;
      page_reg      <= '0;
      pg_start_reg  <= '0;
      pg_end_reg    <= 3'd7;
      skip_reg      <= '0;
      disp_reg      <= 1'b0;
      fb_we_reg     <= 1'b0;
      fb_addr_reg   <= '0;
      fb_data_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      mode_reg      <= mode_next;
      col_reg       <= col_next;
      col_start_reg <= col_start_next;
      col_end_reg   <= col_end_next;
      page_reg      <= page_next;
      pg_start_reg  <= pg_start_next;
      pg_end_reg    <= pg_end_next;
      skip_reg      <= skip_next;
      disp_reg      <= disp_next;
      fb_we_reg     <= fb_we_next;
      fb_addr_reg   <= fb_addr_next;
      fb_data_reg   <= fb_data_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    mode_next      = mode_reg;
    col_next       = col_reg;
    col_start_next = col_start_reg;
    col_end_next   = col_end_reg;
    page_next      = page_reg;
    pg_start_next  = pg_start_reg;
    pg_end_next    = pg_end_reg;
    skip_next      = skip_reg;
    disp_next      = disp_reg;
    fb_we_next     = 1'b0;
    fb_addr_next   = fb_addr_reg;
    fb_data_next   = fb_data_reg;
    if (soft_rst) begin
      state_next     = ST_IDLE;
      mode_next      = MODE_HORIZ;
      col_next       = '0;
      col_start_next = '0;
      col_end_next   = 7'd127;
      page_next      = '0;
      pg_start_next  = '0;
      pg_end_next    = 3'd7;
      skip_next      = '0;
      disp_next      = 1'b0;
    end else if (byte_valid && byte_dc) begin
      // Data always writes, and cancels any half-received command.
      state_next   = ST_IDLE;
      fb_we_next   = 1'b1;
      fb_addr_next = {page_reg, col_reg};
      fb_data_next = byte_out;
      case (mode_reg)
        MODE_HORIZ: begin
          if (col_reg >= col_end_reg) begin
            col_next  = col_start_reg;
            page_next = (page_reg >= pg_end_reg) ? pg_start_reg : page_reg + 3'd1;
          end else begin
            col_next = col_reg + 7'd1;
          end
        end
        MODE_VERT: begin
          if (page_reg >= pg_end_reg) begin
            page_next = pg_start_reg;
            col_next  = (col_reg >= col_end_reg) ? col_start_reg : col_reg + 7'd1;
          end else begin
            page_next = page_reg + 3'd1;
          end
        end
        default: col_next = col_reg + 7'd1;
      endcase
    end else if (byte_valid) begin
      case (state_reg)
        ST_IDLE: begin
          if (byte_out == CMD_COL_ADDR)                 state_next = ST_COL_START;
          else if (byte_out == CMD_PAGE_ADDR)           state_next = ST_PG_START;
          else if (byte_out == CMD_SET_MODE)            state_next = ST_MODE;
          else if (byte_out[7:3] == CMD_PAGE_BASE[7:3]) page_next  = byte_out[2:0];
          else if (byte_out[7:4] == 4'h0)               col_next   = {col_reg[6:4], byte_out[3:0]};
          else if (byte_out[7:4] == 4'h1)               col_next   = {byte_out[2:0], col_reg[3:0]};
          else if (byte_out == CMD_DISP_OFF)            disp_next  = 1'b0;
          else if (byte_out == CMD_DISP_ON)             disp_next  = 1'b1;
          else if (param_count(byte_out) != 3'd0) begin
            state_next = ST_PARAM;
            skip_next  = param_count(byte_out);
          end
        end
        ST_PARAM: begin
          skip_next = skip_reg - 3'd1;
          if (skip_reg <= 3'd1) state_next = ST_IDLE;
        end
        ST_COL_START: begin
          col_start_next = byte_out[6:0];
          state_next     = ST_COL_END;
        end
        ST_COL_END: begin
          col_end_next = byte_out[6:0];
          col_next     = col_start_reg;
          state_next   = ST_IDLE;
        end
        ST_PG_START: begin
          pg_start_next = byte_out[2:0];
          state_next    = ST_PG_END;
        end
        ST_PG_END: begin
          pg_end_next = byte_out[2:0];
          page_next   = pg_start_reg;
          state_next  = ST_IDLE;
        end
        ST_MODE: begin
          if (byte_out[1:0] != 2'b11) mode_next = addr_mode_e'(byte_out[1:0]);
          state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign fb_we      = fb_we_reg;
  assign fb_addr    = fb_addr_reg;
  assign fb_data    = fb_data_reg;
  assign display_on = disp_reg;
`else
  logic unused_soft_rst;
  assign unused_soft_rst = soft_rst;
  assign fb_we      = 1'b0;
  assign fb_addr    = '0;
  assign fb_data    = '0;
  assign display_on = 1'b0;
`endif

endmodule

// File: tb/tb_ssd1306_spi_receiver.sv
// Directed bench for ssd1306_spi_receiver; decoder checks apply when SSD1306_RX_CMD_DECODE_EN is defined.
module tb_ssd1306_spi_receiver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       oled_rstn_in = 1'b1;
  logic       oled_csn_in = 1'b1;
  logic       oled_dc_in = 1'b0;
  logic       oled_clk_in = 1'b0;
  logic       oled_mosi_in = 1'b0;
  logic [7:0] byte_out;
  logic       byte_dc;
  logic       byte_valid;
  logic       frame_err;
  logic       fb_we;
  logic [9:0] fb_addr;
  logic [7:0] fb_data;
  logic       display_on;

  ssd1306_spi_receiver #(.SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .oled_rstn_in (oled_rstn_in),
    .oled_csn_in  (oled_csn_in),
    .oled_dc_in   (oled_dc_in),
    .oled_clk_in  (oled_clk_in),
    .oled_mosi_in (oled_mosi_in),
    .byte_out     (byte_out),
    .byte_dc      (byte_dc),
    .byte_valid   (byte_valid),
    .frame_err    (frame_err),
    .fb_we        (fb_we),
    .fb_addr      (fb_addr),
    .fb_data      (fb_data),
    .display_on   (display_on)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int bv_cnt = 0;
  int fe_cnt = 0;
  int fbw_cnt = 0;
  int we_timing_err = 0;
  int b0, w0, f0;
  logic [9:0] last_addr = '0;
  logic [9:0] prev_addr = '0;
  logic [7:0] last_data = '0;
  logic       bv_dc_d = 1'b0;

  // Event recorder, sampled on the falling edge.
  always @(negedge clk) begin
    if (byte_valid) bv_cnt++;
    if (frame_err) fe_cnt++;
    if (fb_we) begin
      fbw_cnt++;
      prev_addr = last_addr;
      last_addr = fb_addr;
      last_data = fb_data;
    end
`ifdef SSD1306_RX_CMD_DECODE_EN
    if (fb_we !== bv_dc_d) we_timing_err++;
`endif
    bv_dc_d = byte_valid & byte_dc;
  end

  typedef struct {
    logic [7:0] tx;
    logic       dc;
    logic [9:0] addr;
    logic       disp;
  } vec_t;

  vec_t vecs [28];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Sends the top n bits of b MSB first; SCLK high and low are 2 clk each.
  task automatic spi_bits(input logic [7:0] b, input int n, input logic d);
    oled_dc_in = d;
    for (int i = 7; i > 7 - n; i--) begin
      oled_mosi_in = b[i];
      #20 oled_clk_in = 1'b1;
      #20 oled_clk_in = 1'b0;
    end
  endtask

  initial begin
    vecs = '{
      '{8'hAF, 1'b0, 10'h000, 1'b1},
      '{8'h21, 1'b0, 10'h000, 1'b1},
      '{8'h10, 1'b0, 10'h000, 1'b1},
      '{8'h11, 1'b0, 10'h000, 1'b1},
      '{8'h22, 1'b0, 10'h000, 1'b1},
      '{8'h02, 1'b0, 10'h000, 1'b1},
      '{8'h03, 1'b0, 10'h000, 1'b1},
      '{8'hA5, 1'b1, 10'h110, 1'b1},
      '{8'h5A, 1'b1, 10'h111, 1'b1},
      '{8'h3C, 1'b1, 10'h190, 1'b1},
      '{8'hC3, 1'b1, 10'h191, 1'b1},
      '{8'h20, 1'b0, 10'h000, 1'b1},
      '{8'h02, 1'b0, 10'h000, 1'b1},
      '{8'hB5, 1'b0, 10'h000, 1'b1},
      '{8'h0F, 1'b0, 10'h000, 1'b1},
      '{8'h17, 1'b0, 10'h000, 1'b1},
      '{8'h11, 1'b1, 10'h2FF, 1'b1},
      '{8'h22, 1'b1, 10'h280, 1'b1},
      '{8'hAE, 1'b0, 10'h000, 1'b0},
      '{8'hAF, 1'b0, 10'h000, 1'b1},
      '{8'h20, 1'b0, 10'h000, 1'b1},
      '{8'h00, 1'b0, 10'h000, 1'b1},
      '{8'h21, 1'b0, 10'h000, 1'b1},
      '{8'h00, 1'b0, 10'h000, 1'b1},
      '{8'h7F, 1'b0, 10'h000, 1'b1},
      '{8'h22, 1'b0, 10'h000, 1'b1},
      '{8'h00, 1'b0, 10'h000, 1'b1},
      '{8'h07, 1'b0, 10'h000, 1'b1}
    };

    #30;
    chk("rst_byte_out", 32'(byte_out), 'h00);
    chk("rst_byte_dc", 32'(byte_dc), 0);
    chk("rst_byte_valid", 32'(byte_valid), 0);
    chk("rst_frame_err", 32'(frame_err), 0);
    chk("rst_fb_we", 32'(fb_we), 0);
    chk("rst_fb_addr", 32'(fb_addr), 0);
    chk("rst_fb_data", 32'(fb_data), 0);
    chk("rst_display_on", 32'(display_on), 0);
    #20 rst_n = 1'b1;
    #40 oled_csn_in = 1'b0;
    #40;

    for (int v = 0; v < 28; v++) begin
      b0 = bv_cnt;
      w0 = fbw_cnt;
      spi_bits(vecs[v].tx, 8, vecs[v].dc);
      #100;
      chk("vec_byte_valid_count", bv_cnt - b0, 1);
      chk("vec_byte_out", 32'(byte_out), 32'(vecs[v].tx));
      chk("vec_byte_dc", 32'(byte_dc), 32'(vecs[v].dc));
`ifdef SSD1306_RX_CMD_DECODE_EN
      if (vecs[v].dc) begin
        chk("vec_fb_we_count", fbw_cnt - w0, 1);
        chk("vec_fb_addr", 32'(last_addr), 32'(vecs[v].addr));
        chk("vec_fb_data", 32'(last_data), 32'(vecs[v].tx));
      end else begin
        chk("vec_fb_we_count", fbw_cnt - w0, 0);
      end
      chk("vec_display_on", 32'(display_on), 32'(vecs[v].disp));
`else
      chk("vec_fb_we_count", fbw_cnt - w0, 0);
      chk("vec_display_on", 32'(display_on), 0);
`endif
    end

    // Full-range horizontal sweep: 1025 writes wrap back to {0,0}.
    b0 = bv_cnt;
    w0 = fbw_cnt;
    for (int i = 0; i < 1025; i++) spi_bits(8'(i) ^ 8'h5A, 8, 1'b1);
    #100;
    chk("bulk_byte_valid_count", bv_cnt - b0, 1025);
`ifdef SSD1306_RX_CMD_DECODE_EN
    chk("bulk_fb_we_count", fbw_cnt - w0, 1025);
    chk("bulk_addr_1024th", 32'(prev_addr), 'h3FF);
    chk("bulk_addr_last", 32'(last_addr), 'h000);
    chk("bulk_data_last", 32'(last_data), 'h5A);
`else
    chk("bulk_fb_we_count", fbw_cnt - w0, 0);
`endif

    // Aborted partial byte, then a parameterised command whose param is swallowed.
    #40 oled_csn_in = 1'b1;
    #60 oled_csn_in = 1'b0;
    #40;
    f0 = fe_cnt;
    b0 = bv_cnt;
    spi_bits(8'hFF, 5, 1'b0);
    #40 oled_csn_in = 1'b1;
    #100;
    chk("partial_frame_err_count", fe_cnt - f0, 1);
    chk("partial_byte_valid_count", bv_cnt - b0, 0);
    oled_csn_in = 1'b0;
    #40;
    spi_bits(8'h81, 8, 1'b0);
    #100;
    chk("after_err_byte_out", 32'(byte_out), 'h81);
    spi_bits(8'hAE, 8, 1'b0);
    #100;
    chk("param_byte_out", 32'(byte_out), 'hAE);
    chk("param_byte_valid_count", bv_cnt - b0, 2);
`ifdef SSD1306_RX_CMD_DECODE_EN
    chk("param_skip_display_on", 32'(display_on), 1);
`else
    chk("param_skip_display_on", 32'(display_on), 0);
`endif
    oled_csn_in = 1'b1;
    #100;
    chk("clean_release_frame_err", fe_cnt - f0, 1);

    // Soft reset from vertical mode with a partial byte pending.
    oled_csn_in = 1'b0;
    #40;
    spi_bits(8'h20, 8, 1'b0);
    spi_bits(8'h01, 8, 1'b0);
    spi_bits(8'hB3, 8, 1'b0);
    spi_bits(8'h77, 8, 1'b1);
    #100;
`ifdef SSD1306_RX_CMD_DECODE_EN
    chk("pre_soft_rst_addr", 32'(last_addr), 'h181);
`endif
    f0 = fe_cnt;
    spi_bits(8'hF0, 3, 1'b0);
    #40 oled_rstn_in = 1'b0;
    #80 oled_rstn_in = 1'b1;
    #60 oled_csn_in = 1'b1;
    #100;
    chk("soft_rst_no_frame_err", fe_cnt - f0, 0);
    chk("soft_rst_display_on", 32'(display_on), 0);
    oled_csn_in = 1'b0;
    #40;
    w0 = fbw_cnt;
    spi_bits(8'h99, 8, 1'b1);
    #100;
    chk("soft_rst_byte_out", 32'(byte_out), 'h99);
`ifdef SSD1306_RX_CMD_DECODE_EN
    chk("soft_rst_addr0", 32'(last_addr), 'h000);
`endif
    spi_bits(8'h66, 8, 1'b1);
    #100;
    chk("soft_rst_byte_out2", 32'(byte_out), 'h66);
`ifdef SSD1306_RX_CMD_DECODE_EN
    chk("soft_rst_horiz_addr1", 32'(last_addr), 'h001);
    chk("soft_rst_fb_we_count", fbw_cnt - w0, 2);
`else
    chk("soft_rst_fb_we_count", fbw_cnt - w0, 0);
`endif

    // Hard reset mid-byte, then a clean byte.
    spi_bits(8'hC3, 4, 1'b0);
    #20 rst_n = 1'b0;
    #20;
    chk("hard_rst_byte_out", 32'(byte_out), 'h00);
    chk("hard_rst_byte_dc", 32'(byte_dc), 0);
    chk("hard_rst_fb_addr", 32'(fb_addr), 0);
    #20 rst_n = 1'b1;
    #60;
    b0 = bv_cnt;
    spi_bits(8'h3C, 8, 1'b0);
    #100;
    chk("post_rst_byte_out", 32'(byte_out), 'h3C);
    chk("post_rst_byte_valid_count", bv_cnt - b0, 1);
`ifdef SSD1306_RX_CMD_DECODE_EN
    chk("fb_we_follows_byte_valid", we_timing_err, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
